// File: rtl/emu_transactor_step.sv
// Co-emulation transactor: host register file of stimulus/capture words on a byte link,
// with burst addressing and an N-cycle DUT clock-step engine that auto-captures DUT outputs.
module emu_transactor_step #(
  parameter int DATA_W       = 8,
  parameter int NUM_STIM     = 5,
  parameter int NUM_OUT      = 3,
  parameter int ADDR_W       = 3,
  parameter int CNT_W        = 16,
  parameter bit AUTO_CAPTURE = 1'b1
) (
  input  logic                        clk_emu,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           Din_emu,
  output logic [DATA_W-1:0]           Dout_emu,
  input  logic [ADDR_W-1:0]           Addr_emu,
  input  logic                        wr_emu,
  input  logic                        rd_emu,
  input  logic                        burst_emu,
  input  logic                        load_emu,
  input  logic                        get_emu,
  input  logic                        step_emu,
  input  logic [CNT_W-1:0]            step_cnt,
  output logic [NUM_STIM*DATA_W-1:0]  stim_bus,
  input  logic [NUM_OUT*DATA_W-1:0]   vect_bus,
  output logic                        dut_clk_en,
  output logic                        busy_emu,
  output logic                        done_emu
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  localparam logic [ADDR_W:0] A_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] STIM_LIM = (ADDR_W+1)'(NUM_STIM);
  localparam logic [ADDR_W:0] OUT_LIM  = (ADDR_W+1)'(NUM_OUT);

  logic [DATA_W-1:0]          stim_q [NUM_STIM];
  logic [DATA_W-1:0]          stim_d [NUM_STIM];
  logic [DATA_W-1:0]          cap_q  [NUM_OUT];
  logic [DATA_W-1:0]          cap_d  [NUM_OUT];
  logic [NUM_STIM*DATA_W-1:0] stim_bus_q, stim_bus_d;
  logic [DATA_W-1:0]          dout_q, dout_d;
  logic [ADDR_W-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 state_q, state_d;
  logic                       clk_en_q, clk_en_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [ADDR_W-1:0]          wr_ea, rd_ea;
  logic [ADDR_W:0]            wr_nxt, rd_nxt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stim_d     = stim_q;
    cap_d      = cap_q;
    stim_bus_d = stim_bus_q;
    dout_d     = dout_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    clk_en_d   = clk_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    wr_ea  = burst_emu ? wptr_q : Addr_emu;
    rd_ea  = burst_emu ? rptr_q : Addr_emu;
    wr_nxt = {1'b0, wr_ea} + A_ONE;
    rd_nxt = {1'b0, rd_ea} + A_ONE;

    // Out-of-range write addresses match no word and are dropped.
    if (wr_emu) begin
      for (int i = 0; i < NUM_STIM; i++) begin
        if ({1'b0, wr_ea} == (ADDR_W+1)'(i)) stim_d[i] = Din_emu;
      end
      wptr_d = (wr_nxt >= STIM_LIM) ? '0 : wr_nxt[ADDR_W-1:0];
    end

    // Reads see the registered capture words, so a same-cycle capture is not visible yet.
    if (rd_emu) begin
      dout_d = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if ({1'b0, rd_ea} == (ADDR_W+1)'(i)) dout_d = cap_q[i];
      end
      rptr_d = (rd_nxt >= OUT_LIM) ? '0 : rd_nxt[ADDR_W-1:0];
    end

    if (load_emu) begin
      for (int i = 0; i < NUM_STIM; i++) stim_bus_d[i*DATA_W +: DATA_W] = stim_q[i];
    end

    if (get_emu || (state_q == S_CAP && AUTO_CAPTURE)) begin
      for (int i = 0; i < NUM_OUT; i++) cap_d[i] = vect_bus[i*DATA_W +: DATA_W];
    end

    case (state_q)
      S_IDLE: begin
        if (step_emu && step_cnt != '0) begin
          cnt_d    = step_cnt;
          state_d  = S_RUN;
          clk_en_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_CAP;
          clk_en_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      S_CAP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        clk_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // NOTE: the word arrays are ordinary flops that must come up zeroed, so they sit under reset.
  always_ff @(posedge clk_emu or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STIM; i++) stim_q[i] <= '0;
      for (int i = 0; i < NUM_OUT; i++)  cap_q[i]  <= '0;
      stim_bus_q <= '0;
      dout_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      clk_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      stim_q     <= stim_d;
      cap_q      <= cap_d;
      stim_bus_q <= stim_bus_d;
      dout_q     <= dout_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign stim_bus   = stim_bus_q;
  assign Dout_emu   = dout_q;
  assign dut_clk_en = clk_en_q;
  assign busy_emu   = busy_q;
  assign done_emu   = done_q;

endmodule

// File: tb/tb_emu_transactor_step.sv
// Directed bench for emu_transactor_step: host reads are scoreboarded against a small
// register-file model; step-engine timing and reset abort are checked cycle by cycle.
module tb_emu_transactor_step;

  localparam int DW = 8;
  localparam int NS = 5;
  localparam int NO = 3;
  localparam int AW = 3;
  localparam int CW = 16;

  logic              clk_emu = 1'b0;
  logic              reset;
  logic [DW-1:0]     Din_emu;
  logic [DW-1:0]     Dout_emu;
  logic [AW-1:0]     Addr_emu;
  logic              wr_emu, rd_emu, burst_emu, load_emu, get_emu, step_emu;
  logic [CW-1:0]     step_cnt;
  logic [NS*DW-1:0]  stim_bus;
  logic [NO*DW-1:0]  vect_bus;
  logic              dut_clk_en, busy_emu, done_emu;

  emu_transactor_step dut (
    .clk_emu    (clk_emu),
    .reset      (reset),
    .Din_emu    (Din_emu),
    .Dout_emu   (Dout_emu),
    .Addr_emu   (Addr_emu),
    .wr_emu     (wr_emu),
    .rd_emu     (rd_emu),
    .burst_emu  (burst_emu),
    .load_emu   (load_emu),
    .get_emu    (get_emu),
    .step_emu   (step_emu),
    .step_cnt   (step_cnt),
    .stim_bus   (stim_bus),
    .vect_bus   (vect_bus),
    .dut_clk_en (dut_clk_en),
    .busy_emu   (busy_emu),
    .done_emu   (done_emu)
  );

  always #5 clk_emu = ~clk_emu;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] m_stim [NS];
  logic [DW-1:0] m_cap  [NO];
  int            m_wptr, m_rptr;

  task automatic tick();
    @(posedge clk_emu);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS*DW-1:0] m_bus();
    logic [NS*DW-1:0] r;
    for (int i = 0; i < NS; i++) r[i*DW +: DW] = m_stim[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_stim[i] = '0;
    for (int i = 0; i < NO; i++) m_cap[i] = '0;
    m_wptr = 0;
    m_rptr = 0;
    sb_q.delete();
  endtask

  task automatic model_capture();
    for (int i = 0; i < NO; i++) m_cap[i] = vect_bus[i*DW +: DW];
  endtask

  task automatic sb_push_rd(input logic burst, input logic [AW-1:0] addr);
    int ea;
    ea = burst ? m_rptr : int'(addr);
    sb_q.push_back((ea < NO) ? m_cap[ea] : '0);
    m_rptr = (ea + 1 >= NO) ? 0 : ea + 1;
  endtask

  task automatic sb_pop_check(input string tag);
    logic [DW-1:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=0x%0h expected=<empty scoreboard>", tag, Dout_emu);
    end else begin
      exp = sb_q.pop_front();
      check(tag, 64'(Dout_emu), 64'(exp));
    end
  endtask

  task automatic do_wr(input logic burst, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    int ea;
    ea = burst ? m_wptr : int'(addr);
    if (ea < NS) m_stim[ea] = d;
    m_wptr = (ea + 1 >= NS) ? 0 : ea + 1;
    burst_emu = burst; Addr_emu = addr; Din_emu = d; wr_emu = 1'b1;
    tick();
    wr_emu = 1'b0; burst_emu = 1'b0;
  endtask

  task automatic do_rd(input logic burst, input logic [AW-1:0] addr, input string tag);
    sb_push_rd(burst, addr);
    burst_emu = burst; Addr_emu = addr; rd_emu = 1'b1;
    tick();
    rd_emu = 1'b0; burst_emu = 1'b0;
    sb_pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    Din_emu = '0; Addr_emu = '0; wr_emu = 0; rd_emu = 0; burst_emu = 0;
    load_emu = 0; get_emu = 0; step_emu = 0; step_cnt = '0; vect_bus = '0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: reset state
    check("rst_clk_en", 64'(dut_clk_en), 64'd0);
    check("rst_busy", 64'(busy_emu), 64'd0);
    check("rst_stim_bus", 64'(stim_bus), 64'd0);
    for (int a = 0; a < 3; a++) do_rd(1'b0, AW'(a), $sformatf("rst_rd%0d", a));

    // 2: burst writes wrap, then load
    for (int k = 1; k <= 6; k++) do_wr(1'b1, '0, DW'(k * 8'h11));
    load_emu = 1'b1; tick(); load_emu = 1'b0;
    check("load_burst", 64'(stim_bus), 64'h55_44_33_22_66);
    check("load_model", 64'(stim_bus), 64'(m_bus()));

    // write and load together: load takes the old word
    begin
      logic [NS*DW-1:0] exp_bus;
      exp_bus = m_bus();
      m_stim[0] = 8'h99;
      m_wptr = 1;
      Addr_emu = '0; Din_emu = 8'h99; wr_emu = 1'b1; load_emu = 1'b1;
      tick();
      wr_emu = 1'b0; load_emu = 1'b0;
      check("load_with_wr", 64'(stim_bus), 64'(exp_bus));
      load_emu = 1'b1; tick(); load_emu = 1'b0;
      check("load_after_wr", 64'(stim_bus), 64'h55_44_33_22_99);
    end

    // 3: capture then burst reads, out-of-range read
    vect_bus = {8'hC3, 8'h7F, 8'h01};
    model_capture();
    get_emu = 1'b1; tick(); get_emu = 1'b0;
    do_rd(1'b1, '0, "burst_rd0");
    do_rd(1'b1, '0, "burst_rd1");
    do_rd(1'b1, '0, "burst_rd2");
    do_rd(1'b0, 3'd5, "rd_oob");
    tick();
    check("dout_hold", 64'(Dout_emu), 64'd0);

    // get and rd together: read returns pre-capture word
    vect_bus = {8'h5A, 8'h3C, 8'hE1};
    sb_push_rd(1'b0, '0);
    Addr_emu = '0; rd_emu = 1'b1; get_emu = 1'b1;
    tick();
    rd_emu = 1'b0; get_emu = 1'b0;
    model_capture();
    sb_pop_check("rd_with_get");
    do_rd(1'b0, '0, "rd_after_get");

    // 4: step run of 4 with an ignored re-trigger
    vect_bus = {8'hAA, 8'hBB, 8'hCC};
    step_cnt = 16'd4; step_emu = 1'b1;
    tick();
    step_emu = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("run_clk_en_c%0d", c), 64'(dut_clk_en), 64'(c <= 4));
      check($sformatf("run_busy_c%0d", c), 64'(busy_emu), 64'(c <= 5));
      check($sformatf("run_done_c%0d", c), 64'(done_emu), 64'(c == 5));
      step_emu = (c == 2);
      tick();
    end
    step_emu = 1'b0;
    model_capture();
    for (int a = 0; a < 3; a++) do_rd(1'b0, AW'(a), $sformatf("auto_cap%0d", a));

    step_cnt = '0; step_emu = 1'b1;
    tick();
    step_emu = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("zero_cnt_clk_en_c%0d", c), 64'(dut_clk_en), 64'd0);
      check($sformatf("zero_cnt_busy_c%0d", c), 64'(busy_emu), 64'd0);
      tick();
    end

    // 5: reset in the middle of a long run
    step_cnt = 16'd100; step_emu = 1'b1;
    tick();
    step_emu = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    check("long_run_clk_en", 64'(dut_clk_en), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("abort_clk_en", 64'(dut_clk_en), 64'd0);
    check("abort_busy", 64'(busy_emu), 64'd0);
    check("abort_done", 64'(done_emu), 64'd0);
    check("abort_dout", 64'(Dout_emu), 64'd0);
    check("abort_stim_bus", 64'(stim_bus), 64'd0);
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("post_abort_busy_c%0d", c), 64'(busy_emu), 64'd0);
      check($sformatf("post_abort_done_c%0d", c), 64'(done_emu), 64'd0);
      tick();
    end
    do_rd(1'b1, '0, "post_abort_cap0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
